mod_dec_shifter: RTL and testbench
==================================

// Module: mod_dec_shifter
// PURPOSE
// - AES-256 decryption InvShiftRows stage; the inverse of the encryption ShiftRows shifter.
// - Sits between the decrypt AddRoundKey and InvSubBytes in the decryption datapath.
// - Registered stage with valid/ready handshakes on both sides and a 2-entry skid buffer.
// - Sustains 1 state per cycle under backpressure.
// PARAMETERS
// - CNT_W   default 16   width of the processed-block counter (blk_cnt)
// - DEPTH   default 2    skid buffer entries; only 2 is supported, elaborate $error otherwise
// PORTS
// - clk        in   1         rising-edge clock, single clock domain
// - rst        in   1         synchronous, active-high reset
// - in_valid   in   1         p00 and in_bypass are valid this cycle
// - in_ready   out  1         stage accepts a state this cycle
// - p00        in   [15:0][7:0]  input state; byte k = 4*r + c (row r, column c)
// - in_bypass  in   1         1: pass state unshifted (test/debug), travels with data
// - out_valid  out  1         o00 valid
// - out_ready  in   1         downstream accepts o00 this cycle
// - o00        out  [15:0][7:0]  output state, same byte layout as p00
// - blk_cnt    out  CNT_W     number of states delivered (out_valid & out_ready)
// BEHAVIOUR
// - Transform: o[4r+c] = p[4r + ((c - r) mod 4)], i.e. row r rotated right by r bytes.
// - Bypass: o = p unchanged.
// - Transform is applied at input capture; the buffer stores post-shift data.
// - Reset: out_valid=0, in_ready=0 during reset and 1 on the first cycle after it.
// - Reset: o00=0, blk_cnt=0, and the buffer is emptied.
// - Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
// - Latency: a state accepted in cycle N is presented on o00 in cycle N+1 (head entry).
// - Buffer: 2-entry FIFO with an occupancy count in {0,1,2}.
// - in_ready is registered: in_ready = (count < 2) computed from next-state occupancy.
// - No combinational path from out_ready to in_ready.
// - Simultaneous input and output transfer: count unchanged, order preserved.
// - Full (count=2): in_ready=0; in_valid is ignored and no data is dropped or overwritten.
// - Empty: out_valid=0; o00 holds its last value and is not cleared.
// - Ordering is strict FIFO; in_bypass stays paired with its own state.
// - o00 and out_valid are stable while out_valid & !out_ready (AXI-style hold).
// - blk_cnt increments once per output transfer and wraps 2^CNT_W-1 -> 0 silently.
// - Reset mid-operation flushes both entries; in-flight states are lost by design.
// - Upstream must not retract in_valid. This is not checked; the stage only samples on transfer.
// STRUCTURE
// - aes_pkg holds: typedef logic [15:0][7:0] aes_state_t.
// - aes_pkg holds: function inv_shift_rows(aes_state_t) -> aes_state_t.
// - aes_pkg holds: function shift_rows(aes_state_t) -> aes_state_t, shared with mod_enc_shifter.
// - aes_pkg holds: localparam AES_NB = 4.
// - One sub-module: mod_skid_buf2 (2-entry valid/ready buffer, payload width 129 = state + bypass).
// - Top module = package function + mod_skid_buf2 + blk_cnt counter.
// TESTING
// - Row test: rows r0=00..03, r1=10..13, r2=20..23, r3=30..33, bypass=0.
//   -> o rows 00 01 02 03 | 13 10 11 12 | 22 23 20 21 | 31 32 33 30 one cycle later.
// - Round trip: drive shift_rows(X) for X = 00112233445566778899AABBCCDDEEFF.
//   -> o00 == X exactly; with bypass=1, o00 == input.
// - Backpressure: out_ready=0, push 3 states A, B, C.
//   -> A and B accepted, in_ready=0 while C is held.
//   -> out_ready=1 releases A, B, C in order, one per cycle, blk_cnt=3.
// - Streaming: in_valid=out_ready=1 for 100 cycles.
//   -> 100 outputs, no bubbles after the first, blk_cnt=100.
// - Wrap: CNT_W=4, deliver 17 states -> blk_cnt=1.
// - Reset mid-stream: fill 2 entries, assert rst 1 cycle.
//   -> out_valid=0, blk_cnt=0 next cycle, in_ready=1 the cycle after reset deasserts.
//   -> no flushed data ever appears on o00 with out_valid=1.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: AES state type, column count and the ShiftRows / InvShiftRows byte permutations
package aes_pkg;
  localparam int AES_NB = 4;
  typedef logic [15:0][7:0] aes_state_t;
  function automatic aes_state_t inv_shift_rows(aes_state_t p);
    aes_state_t o;
    for (int r = 0; r < AES_NB; r++)
      for (int c = 0; c < AES_NB; c++)
        o[AES_NB*r+c] = p[AES_NB*r+(c-r+AES_NB)%AES_NB];
    return o;
  endfunction
  function automatic aes_state_t shift_rows(aes_state_t p);
    aes_state_t o;
    for (int r = 0; r < AES_NB; r++)
      for (int c = 0; c < AES_NB; c++)
        o[AES_NB*r+c] = p[AES_NB*r+(c+r)%AES_NB];
    return o;
  endfunction
endpackage

// File: rtl/mod_skid_buf2.sv
// mod_skid_buf2: 2-entry valid/ready FIFO (clk, rst, in_valid/in_ready/din -> out_valid/out_ready/dout), registered in_ready
module mod_skid_buf2 #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);
  logic [1:0] cnt, cnt_n;
  logic [W-1:0] h, t;
  logic push, pop;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign cnt_n = cnt + 2'(push) - 2'(pop);
  assign out_valid = cnt != 2'd0;
  assign dout = h;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      h <= '0;
      t <= '0;
      in_ready <= 1'b0;
    end else begin
      cnt <= cnt_n;
      in_ready <= cnt_n < 2'd2;
      if (push && cnt_n == 2'd1) h <= din;
      else if (pop && cnt == 2'd2) h <= t;
      if (push && cnt_n == 2'd2) t <= din;
    end
  end
endmodule

// File: rtl/mod_dec_shifter.sv
// mod_dec_shifter: registered InvShiftRows stage (p00/in_bypass in via in_valid/in_ready, o00 out via out_valid/out_ready, blk_cnt delivered count)
module mod_dec_shifter
  import aes_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0][7:0]  p00,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0][7:0]  o00,
  output logic [CNT_W-1:0]  blk_cnt
);
  if (DEPTH != 2) begin : g_depth
    $error("mod_dec_shifter: only DEPTH=2 is supported");
  end
  aes_state_t din;
  logic [128:0] dout;
  logic unused_byp;
  assign din = in_bypass ? p00 : inv_shift_rows(p00);
  assign {o00, unused_byp} = dout;
  mod_skid_buf2 #(.W(129)) u_buf (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din({din, in_bypass}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout(dout)
  );
  always_ff @(posedge clk) begin
    if (rst) blk_cnt <= '0;
    else if (out_valid && out_ready) blk_cnt <= blk_cnt + 1'b1;
  end
endmodule

// File: tb/tb_mod_dec_shifter.sv
// tb_mod_dec_shifter: scoreboard bench for mod_dec_shifter
module tb_mod_dec_shifter;
  typedef logic [15:0][7:0] st_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bypass = 1'b0;
  logic out_ready = 1'b0;
  st_t p00 = '0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  st_t o00, o00_4;
  logic [15:0] blk_cnt;
  logic [3:0] blk_cnt4;
  st_t q[$];
  int checks = 0;
  int failures = 0;
  int ndel = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  mod_dec_shifter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .p00(p00),
    .in_bypass(in_bypass), .out_valid(out_valid), .out_ready(out_ready), .o00(o00), .blk_cnt(blk_cnt)
  );
  mod_dec_shifter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .p00(p00),
    .in_bypass(in_bypass), .out_valid(out_valid4), .out_ready(out_ready), .o00(o00_4), .blk_cnt(blk_cnt4)
  );
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask
  function automatic st_t m_inv(st_t p);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[4*r+(c+r)%4] = p[4*r+c];
    return o;
  endfunction
  function automatic st_t m_fwd(st_t p);
    st_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[4*r+c] = p[4*r+(c+r)%4];
    return o;
  endfunction
  function automatic st_t rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      ndel = 0;
    end else if (out_valid && out_ready) begin
      chk("sb_nonempty", 128'(q.size() != 0), 128'd1);
      if (q.size() != 0) chk("o00", o00, q.pop_front());
      chk("blk_cnt", blk_cnt, ndel[15:0]);
      ndel++;
    end
  end
  task automatic send(input st_t st, input logic b, input st_t e);
    in_valid = 1'b1;
    p00 = st;
    in_bypass = b;
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
    chk("send_ready", 128'(in_ready), 128'd1);
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
    chk("drain", 128'(q.size()), 128'd0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    st_t rowp, rowe, x, a, b, c;
    logic [7:0] er[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h13, 8'h10, 8'h11, 8'h12,
                           8'h22, 8'h23, 8'h20, 8'h21, 8'h31, 8'h32, 8'h33, 8'h30};
    int t_first, base;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_o00", o00, 128'd0);
    chk("rst_blk_cnt", blk_cnt, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rowp[k] = 8'((k / 4) * 16 + k % 4);
      rowe[k] = er[k];
    end
    send(rowp, 1'b0, rowe);
    chk("row_latency_valid", 128'(out_valid), 128'd1);
    chk("row_latency_o00", o00, rowe);
    drain();
    x = 128'h00112233445566778899AABBCCDDEEFF;
    send(m_fwd(x), 1'b0, x);
    send(x, 1'b1, x);
    for (int i = 0; i < 4; i++) begin
      a = rnd();
      send(a, i[0], i[0] ? a : m_inv(a));
    end
    drain();
    do_reset();
    out_ready = 1'b0;
    a = rnd(); b = rnd(); c = rnd();
    send(a, 1'b0, m_inv(a));
    send(b, 1'b1, b);
    in_valid = 1'b1;
    p00 = c;
    in_bypass = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("full_in_ready", 128'(in_ready), 128'd0);
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_o00", o00, q[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(c, 1'b0, m_inv(c));
    drain();
    chk("bp_blk_cnt", blk_cnt, 128'd3);
    do_reset();
    out_ready = 1'b1;
    base = ndel;
    fork
      for (int i = 0; i < 100; i++) begin
        a = rnd();
        send(a, 1'b0, m_inv(a));
      end
      begin
        t_first = -1;
        for (int n = 0; n < 300 && ndel < base + 100; n++) begin
          @(negedge clk);
          if (t_first < 0 && ndel > base) t_first = cyc;
        end
      end
    join
    chk("stream_count", 128'(ndel - base), 128'd100);
    chk("stream_bubbles", 128'(cyc - t_first), 128'd99);
    drain();
    chk("stream_blk_cnt", blk_cnt, 128'd100);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a = rnd();
      send(a, 1'b1, a);
    end
    drain();
    chk("wrap_blk_cnt4", blk_cnt4, 128'd1);
    chk("wrap_blk_cnt16", blk_cnt, 128'd17);
    out_ready = 1'b0;
    a = rnd(); b = rnd();
    send(a, 1'b0, m_inv(a));
    send(b, 1'b0, m_inv(b));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_blk_cnt", blk_cnt, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", 128'(in_ready), 128'd1);
    chk("midrst_empty", 128'(out_valid), 128'd0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_ghost", 128'(ndel), 128'd0);
    c = rnd();
    send(c, 1'b0, m_inv(c));
    drain();
    chk("final_blk_cnt", blk_cnt, 128'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
